// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, capture FSM encoding, default FIFO depth.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Default buffer depth, shared by the RX-side and TX-side FIFOs.
    localparam int UART_FIFO_DEPTH = 16;

    // Receive capture handshake states.
    typedef enum logic [1:0] {
        CAP_IDLE     = 2'd0,
        CAP_ACK      = 2'd1,
        CAP_WAIT_LOW = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_fifo_core.sv
// Generic synchronous first-word-fall-through FIFO with push/pop/flush/count.
// Occupancy is tracked in its own register so full/empty never depend on
// pointer comparison; pointers simply wrap modulo DEPTH.
module uart_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Flush wins over any same-cycle push or pop.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && valid_o && !flush_i;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
                2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer: takes bytes from the UART receiver's held-byte handshake
// into a FWFT FIFO and flags overrun when the receiver waits on a full FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  rx_ready_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    output logic                  rx_ack_o,
    input  logic                  read_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overrun_o
);

    cap_state_e state_q, state_d;
    logic       ack_q, ack_d;
    logic       overrun_q, overrun_d;
    logic       capture;

    uart_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .push_i      (capture),
        .push_data_i (rx_data_i),
        .pop_i       (read_i),
        .flush_i     (flush_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .full_o      (full_o),
        .count_o     (count_o)
    );

    assign rx_ack_o  = ack_q;
    assign overrun_o = overrun_q;

    // Capture FSM: take one byte per ready assertion, then wait for ready to drop.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (rx_ready_i && !full_o) begin
                    capture = 1'b1;
                    state_d = CAP_ACK;
                end
            end
            CAP_ACK:      state_d = CAP_WAIT_LOW;
            CAP_WAIT_LOW: if (!rx_ready_i) state_d = CAP_IDLE;
            default:      state_d = CAP_IDLE;
        endcase
        ack_d = capture;
    end

    // Sticky overrun: a fresh byte waiting while full; cleared only by flush.
    always_comb begin
        overrun_d = overrun_q;
        if (flush_i) begin
            overrun_d = 1'b0;
        end else if (state_q == CAP_IDLE && rx_ready_i && full_o) begin
            overrun_d = 1'b1;
        end
    end

    // FSM state, acknowledge pulse and overrun registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= CAP_IDLE;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receiver and the host/bus logic.
- Consumes the receiver's held-byte handshake: `rx_ready_i`/`rx_data_i` in, one-cycle `rx_ack_o` out.
- Stores bytes in a DEPTH-entry FIFO, so the host can drain them in bursts without losing back-to-back characters.
- Read side is first-word-fall-through.

Parameters:
- DATA_WIDTH, 8, byte width; must match the receiver data bus.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clock_i  in  1  system clock; all logic rising-edge.
- reset_i  in  1  asynchronous, active-low reset.
- rx_ready_i  in  1  receiver holds a valid byte; level, stays high until acknowledged.
- rx_data_i  in  DATA_WIDTH  received byte; valid while rx_ready_i=1.
- rx_ack_o  out  1  one-cycle pulse; byte taken into FIFO.
- read_i  in  1  host pops head entry; ignored when valid_o=0.
- flush_i  in  1  synchronous clear of FIFO contents and overrun_o.
- data_o  out  DATA_WIDTH  head entry (FWFT); 0 when empty.
- valid_o  out  1  FIFO not empty.
- full_o  out  1  count_o == DEPTH.
- count_o  out  ADDR_WIDTH+1  entries held, 0..DEPTH.
- overrun_o  out  1  sticky: receiver had a byte waiting while FIFO full.

Behaviour:
- Reset (reset_i=0, async):
  - pointers=0, count_o=0.
  - valid_o=0, full_o=0, rx_ack_o=0, overrun_o=0, data_o=0.
  - FSM=IDLE.
  - Storage RAM is not reset.
- Capture FSM, three states:
  - IDLE: if rx_ready_i=1 and full_o=0 → write rx_data_i at wr_ptr, wr_ptr+1, assert rx_ack_o next cycle, go ACK.
  - ACK: rx_ack_o=1 for exactly this cycle → go WAIT_LOW.
  - WAIT_LOW: stay until rx_ready_i=0 → IDLE. This guarantees one capture per byte regardless of receiver ack-to-ready latency.
- Write latency: byte in entry at edge N sees valid_o=1 and data_o=byte after edge N (visible cycle N+1). rx_ack_o is high in cycle N+1.
- Read: read_i=1 and valid_o=1 → rd_ptr+1 at the edge; data_o shows the next entry the following cycle.
- Simultaneous write and read in one cycle:
  - count_o unchanged; both pointers advance.
  - Allowed only when the FSM condition above holds (full_o is the registered value).
  - A read in a cycle where full_o=1 does not enable a same-cycle write; capture happens the following cycle.
- Full: full_o=1 with rx_ready_i=1 → no capture, no ack. The byte stays held in the receiver and overrun_o sets at the next edge (sticky). Capture resumes automatically once a read frees an entry.
- Empty: read_i ignored; pointers and count unchanged; no underflow.
- Wrap-around: pointers are ADDR_WIDTH bits and wrap modulo DEPTH. count_o is a separate register; full/empty derive from count_o.
- flush_i=1 (synchronous):
  - pointers=0, count_o=0, overrun_o=0.
  - Takes priority over a same-cycle read and write; the write is discarded.
  - The FSM is not reset, so an ACK or WAIT_LOW in progress completes normally.
- Reset mid-operation: any pending ack is dropped. The receiver keeps rx_ready_i high and the byte is captured after reset release.
- rx_ack_o is registered; data_o is a combinational read of RAM[rd_ptr] gated by valid_o.

Decomposition:
- Shared uart package:
  - UART_DATA_WIDTH=8.
  - FSM state encoding for capture (IDLE=2'd0, ACK=2'd1, WAIT_LOW=2'd2).
  - Default FIFO depth constant, also reused by the planned TX-side FIFO.
- One natural sub-module: uart_fifo_core, a generic synchronous FWFT FIFO with push/pop/flush/count.
  - uart_rx_fifo = uart_fifo_core + capture FSM + overrun flag.
  - The TX-side FIFO will instantiate the same core.

Test Plan:
- Reset then idle: assert reset_i=0 mid-run → all outputs 0 immediately (async); after release count_o=0, valid_o=0.
- Single byte: rx_ready_i=1, rx_data_i=8'hA5, drop ready 2 cycles after ack → exactly one rx_ack_o pulse, count_o=1, data_o=8'hA5. read_i one cycle → valid_o=0.
- Ordering and wrap: push 0x00..0x13 (20 bytes) interleaved with reads keeping ≤16 held → reads return 0x00..0x13 in order; pointers wrap without loss.
- Full/overrun: push 16 bytes, present 17th = 8'h5A → full_o=1, no ack, overrun_o=1. One read → 8'h5A captured, count_o=16, overrun_o stays 1 until flush_i.
- Simultaneous read+write at count_o=3 → count_o stays 3, head advances, new byte lands at tail.
- Ready held long: rx_ready_i held 10 cycles after ack → only one entry written (WAIT_LOW guard). flush_i with count_o=5 → count_o=0, valid_o=0, overrun_o=0 next cycle.
